// File: rtl/hmvq6_sel_if.sv
// Bus bundle for hmvq6_sel: strobe, code and loop-filter outputs in; selection vector and status out.
interface hmvq6_sel_if #(
    parameter int unsigned TIE_CNT_W = 16
);
    logic                 clk_en;
    logic [2:0]           code;
    logic [5:0]           sfm5;
    logic [5:0]           sfm4;
    logic [5:0]           sfm3;
    logic [5:0]           sfm2;
    logic [5:0]           sfm1;
    logic [5:0]           sfm0;
    logic                 ovf_clr;
    logic [5:0]           sv;
    logic [2:0]           ptr;
    logic                 ovf_flag;
    logic [TIE_CNT_W-1:0] tie_cnt;

    modport master (
        output clk_en, code, sfm5, sfm4, sfm3, sfm2, sfm1, sfm0, ovf_clr,
        input  sv, ptr, ovf_flag, tie_cnt
    );

    modport slave (
        input  clk_en, code, sfm5, sfm4, sfm3, sfm2, sfm1, sfm0, ovf_clr,
        output sv, ptr, ovf_flag, tie_cnt
    );
endinterface

// File: rtl/hmvq6_sel.sv
// Six-element mismatch-shaping vector quantizer with combinational selection.
// Define HMVQ6_LFSR_TIEBREAK_EN for a pseudo-random tie-break start index instead of round-robin.
module hmvq6_sel #(
    parameter int unsigned TIE_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    hmvq6_sel_if.slave  bus
);
    localparam int unsigned N_EL  = 6;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned SFM_W = 6;
    localparam logic [IDX_W-1:0] CODE_ILLEGAL = IDX_W'(7);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_EL - 1);

    logic [SFM_W-1:0]     sfm_c  [N_EL];
    logic [IDX_W-1:0]     rank_c [N_EL];
    logic [IDX_W-1:0]     beat_c [N_EL];
    logic [IDX_W-1:0]     n_c;
    logic [N_EL-1:0]      sv_c;
    logic                 tie_c;
    logic [IDX_W-1:0]     ptr_step_c;

    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 ovf_q, ovf_d;
    logic [TIE_CNT_W-1:0] tie_q, tie_d;

    assign sfm_c[0] = bus.sfm0;
    assign sfm_c[1] = bus.sfm1;
    assign sfm_c[2] = bus.sfm2;
    assign sfm_c[3] = bus.sfm3;
    assign sfm_c[4] = bus.sfm4;
    assign sfm_c[5] = bus.sfm5;

    assign n_c = (bus.code == CODE_ILLEGAL) ? IDX_W'(N_EL) : bus.code;

    // Rank of each element relative to the tie-break start index, (i - ptr) mod 6
    always_comb begin
        for (int i = 0; i < int'(N_EL); i++) begin
            if (IDX_W'(i) >= ptr_q) begin
                rank_c[i] = IDX_W'(i) - ptr_q;
            end else begin
                rank_c[i] = IDX_W'(i) + IDX_W'(N_EL) - ptr_q;
            end
        end
    end

    // Element i is selected when fewer than n elements beat it
    always_comb begin
        sv_c = '0;
        for (int i = 0; i < int'(N_EL); i++) begin
            beat_c[i] = '0;
            for (int j = 0; j < int'(N_EL); j++) begin
                if ((j != i) &&
                    ((sfm_c[j] > sfm_c[i]) ||
                     ((sfm_c[j] == sfm_c[i]) && (rank_c[j] < rank_c[i])))) begin
                    beat_c[i] = beat_c[i] + IDX_W'(1);
                end
            end
            sv_c[i] = (beat_c[i] < n_c);
        end
    end

    // A selected and an unselected element share the same filter value
    always_comb begin
        tie_c = 1'b0;
        for (int i = 0; i < int'(N_EL); i++) begin
            for (int j = 0; j < int'(N_EL); j++) begin
                if (sv_c[i] && !sv_c[j] && (sfm_c[i] == sfm_c[j])) begin
                    tie_c = 1'b1;
                end
            end
        end
    end

`ifdef HMVQ6_LFSR_TIEBREAK_EN
    localparam int unsigned LFSR_W = 7;
    localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step_c;

    assign lfsr_step_c = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    assign ptr_step_c  = (lfsr_step_c[2:0] < IDX_W'(N_EL)) ? lfsr_step_c[2:0]
                                                          : lfsr_step_c[2:0] - IDX_W'(N_EL);

    always_comb begin
        lfsr_d = lfsr_q;
        if (bus.clk_en) begin
            lfsr_d = lfsr_step_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign ptr_step_c = (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_W'(1);
`endif

    // Set of the overflow flag wins over a same-cycle clear
    always_comb begin
        ptr_d = ptr_q;
        ovf_d = ovf_q;
        tie_d = tie_q;
        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (bus.clk_en) begin
            ptr_d = ptr_step_c;
            if (bus.code == CODE_ILLEGAL) begin
                ovf_d = 1'b1;
            end
            if (tie_c && (tie_q != '1)) begin
                tie_d = tie_q + TIE_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            ovf_q <= 1'b0;
            tie_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
            tie_q <= tie_d;
        end
    end

    assign bus.sv       = sv_c;
    assign bus.ptr      = ptr_q;
    assign bus.ovf_flag = ovf_q;
    assign bus.tie_cnt  = tie_q;
endmodule

// File: tb/tb_hmvq6_sel.sv
// Self-checking bench for hmvq6_sel: vector table, corner sequences and randomized run against a sort-based model.
module tb_hmvq6_sel;
    localparam int unsigned W     = 16;
    localparam int unsigned W_SAT = 4;
    localparam int TIE_MAX     = (1 << W) - 1;
    localparam int TIE_SAT_MAX = (1 << W_SAT) - 1;

    logic clk = 1'b0;
    logic rst;

    hmvq6_sel_if #(.TIE_CNT_W(W))     bif ();
    hmvq6_sel_if #(.TIE_CNT_W(W_SAT)) sif ();

    hmvq6_sel #(.TIE_CNT_W(W))     dut     (.clk(clk), .rst(rst), .bus(bif.slave));
    hmvq6_sel #(.TIE_CNT_W(W_SAT)) dut_sat (.clk(clk), .rst(rst), .bus(sif.slave));

    assign sif.clk_en  = bif.clk_en;
    assign sif.code    = bif.code;
    assign sif.ovf_clr = bif.ovf_clr;
    assign sif.sfm0    = bif.sfm0;
    assign sif.sfm1    = bif.sfm1;
    assign sif.sfm2    = bif.sfm2;
    assign sif.sfm3    = bif.sfm3;
    assign sif.sfm4    = bif.sfm4;
    assign sif.sfm5    = bif.sfm5;

    always #5 clk = ~clk;

    typedef struct {
        int          code;
        logic [35:0] sfm;      // {sfm5, sfm4, ..., sfm0}
        logic [5:0]  exp_sv;
        bit          exp_tie;
        bit          rr_only;  // expectation depends on round-robin ptr
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    int cur_code;
    bit cur_en, cur_clr, cur_rst;
    int cur_s [6];

    int ptr_m, tie_m, tie4_m, lfsr_m;
    bit ovf_m;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int clampn(input int c);
        return (c == 7) ? 6 : c;
    endfunction

    // Pick the n highest-priority elements; priority = sfm, then lower rank
    function automatic logic [5:0] ref_sv(input int c, input int s [6], input int p);
        int  key [6];
        bit  used [6];
        logic [5:0] r;
        int  n, best;
        r = '0;
        n = clampn(c);
        for (int i = 0; i < 6; i++) begin
            key[i]  = s[i] * 8 + (5 - ((i - p + 6) % 6));
            used[i] = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            best = -1;
            for (int i = 0; i < 6; i++)
                if (!used[i] && (best < 0 || key[i] > key[best])) best = i;
            used[best] = 1'b1;
            r[best]    = 1'b1;
        end
        return r;
    endfunction

    function automatic bit ref_tie(input int c, input int s [6], input int p);
        logic [5:0] sel;
        int mn, mx, n;
        n = clampn(c);
        if (n == 0 || n == 6) return 1'b0;
        sel = ref_sv(c, s, p);
        mn = 1000;
        mx = -1;
        for (int i = 0; i < 6; i++) begin
            if (sel[i] && s[i] < mn) mn = s[i];
            if (!sel[i] && s[i] > mx) mx = s[i];
        end
        return mn == mx;
    endfunction

    task automatic model_step();
        if (cur_rst) begin
            ptr_m = 0; ovf_m = 1'b0; tie_m = 0; tie4_m = 0; lfsr_m = 1;
        end else begin
            if (cur_en) begin
                if (ref_tie(cur_code, cur_s, ptr_m)) begin
                    if (tie_m < TIE_MAX) tie_m++;
                    if (tie4_m < TIE_SAT_MAX) tie4_m++;
                end
`ifdef HMVQ6_LFSR_TIEBREAK_EN
                lfsr_m = ((lfsr_m * 2) % 128) + (((lfsr_m >> 6) ^ (lfsr_m >> 5)) & 1);
                ptr_m  = (lfsr_m % 8) % 6;
`else
                ptr_m = (ptr_m + 1) % 6;
`endif
            end
            if (cur_en && cur_code == 7) ovf_m = 1'b1;
            else if (cur_clr) ovf_m = 1'b0;
        end
    endtask

    task automatic drive();
        rst         = cur_rst;
        bif.clk_en  = cur_en;
        bif.ovf_clr = cur_clr;
        bif.code    = 3'(cur_code);
        bif.sfm0    = 6'(cur_s[0]);
        bif.sfm1    = 6'(cur_s[1]);
        bif.sfm2    = 6'(cur_s[2]);
        bif.sfm3    = 6'(cur_s[3]);
        bif.sfm4    = 6'(cur_s[4]);
        bif.sfm5    = 6'(cur_s[5]);
    endtask

    task automatic set_sfm(input logic [35:0] packed_s);
        for (int i = 0; i < 6; i++) cur_s[i] = int'(packed_s[6*i +: 6]);
    endtask

    // One clock: check sv before the edge, registers just after it
    task automatic cycle(input bit do_sv);
        drive();
        #1;
        if (do_sv) begin
            chk("sv", bif.sv, ref_sv(cur_code, cur_s, ptr_m));
            chk("popcount", $countones(bif.sv), clampn(cur_code));
        end
        @(posedge clk);
        model_step();
        #1;
        chk("ptr", bif.ptr, ptr_m);
        chk("ovf_flag", bif.ovf_flag, ovf_m);
        chk("tie_cnt", bif.tie_cnt, tie_m);
        chk("tie_cnt_sat", sif.tie_cnt, tie4_m);
    endtask

    function automatic vec_t mkv(input int c, input int s5, input int s4, input int s3,
                                 input int s2, input int s1, input int s0,
                                 input logic [5:0] sv, input bit tie, input bit rr);
        vec_t v;
        v.code    = c;
        v.sfm     = {6'(s5), 6'(s4), 6'(s3), 6'(s2), 6'(s1), 6'(s0)};
        v.exp_sv  = sv;
        v.exp_tie = tie;
        v.rr_only = rr;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        int exp_cnt;
        int p0, t0;

        // Equal inputs rotate through the ring; then distinct values and extremes
        tbl.push_back(mkv(3, 10,10,10,10,10,10, 6'b000111, 1, 1));
        tbl.push_back(mkv(3, 10,10,10,10,10,10, 6'b001110, 1, 1));
        tbl.push_back(mkv(3, 10,10,10,10,10,10, 6'b011100, 1, 1));
        tbl.push_back(mkv(3, 10,10,10,10,10,10, 6'b111000, 1, 1));
        tbl.push_back(mkv(3, 10,10,10,10,10,10, 6'b110001, 1, 1));
        tbl.push_back(mkv(3, 10,10,10,10,10,10, 6'b100011, 1, 1));
        tbl.push_back(mkv(3, 10,10,10,10,10,10, 6'b000111, 1, 1));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mkv(2, 40,3,22,9,50,1, 6'b100010, 0, 0));
        tbl.push_back(mkv(0, 5,5,5,5,5,5,        6'b000000, 0, 0));
        tbl.push_back(mkv(0, 63,1,17,42,0,8,     6'b000000, 0, 0));
        tbl.push_back(mkv(6, 12,12,12,12,12,12,  6'b111111, 0, 0));
        tbl.push_back(mkv(6, 0,63,31,7,44,2,     6'b111111, 0, 0));
        tbl.push_back(mkv(3, 30,20,20,10,5,0,    6'b111000, 0, 0));
        tbl.push_back(mkv(1, 7,7,7,7,7,9,        6'b000001, 0, 0));

        ptr_m = 0; ovf_m = 1'b0; tie_m = 0; tie4_m = 0; lfsr_m = 1;

        cur_rst = 1'b1; cur_en = 1'b1; cur_clr = 1'b0; cur_code = 3;
        for (int i = 0; i < 6; i++) cur_s[i] = 10;
        cycle(1'b0);
        chk("rst_ptr", bif.ptr, 0);
        chk("rst_ovf", bif.ovf_flag, 0);
        chk("rst_tie", bif.tie_cnt, 0);

        cur_rst = 1'b0;
        exp_cnt = 0;
        for (int k = 0; k < tbl.size(); k++) begin
            cur_code = tbl[k].code;
            set_sfm(tbl[k].sfm);
            drive();
            #1;
`ifdef HMVQ6_LFSR_TIEBREAK_EN
            if (!tbl[k].rr_only) chk($sformatf("tbl_sv[%0d]", k), bif.sv, tbl[k].exp_sv);
`else
            chk($sformatf("tbl_sv[%0d]", k), bif.sv, tbl[k].exp_sv);
`endif
            cycle(1'b1);
            exp_cnt += int'(tbl[k].exp_tie);
            chk($sformatf("tbl_tie[%0d]", k), bif.tie_cnt, exp_cnt);
        end
        chk("tbl_ovf", bif.ovf_flag, 0);

        // Illegal code: full selection, flag set; set beats a held clear
        cur_code = 7;
        for (int i = 0; i < 6; i++) cur_s[i] = int'($urandom_range(63, 0));
        drive();
        #1;
        chk("ill_sv", bif.sv, 6'h3f);
        cycle(1'b1);
        chk("ill_ovf_set", bif.ovf_flag, 1);
        cur_clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1);
            chk("ill_ovf_hold", bif.ovf_flag, 1);
        end
        cur_code = 3;
        cycle(1'b1);
        chk("ill_ovf_clr", bif.ovf_flag, 0);
        cur_clr = 1'b0;

        // clk_en low: registers frozen while sv keeps tracking inputs
        p0 = ptr_m;
        t0 = tie_m;
        cur_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cur_code = int'($urandom_range(6, 0));
            for (int i = 0; i < 6; i++) cur_s[i] = int'($urandom_range(3, 0));
            cycle(1'b1);
        end
        chk("hold_ptr", bif.ptr, p0);
        chk("hold_tie", bif.tie_cnt, t0);

        // Saturation of the narrow counter under a constant boundary tie
        cur_rst = 1'b1; cur_en = 1'b1; cur_code = 3;
        for (int i = 0; i < 6; i++) cur_s[i] = 20;
        cycle(1'b1);
        chk("sat_rst", sif.tie_cnt, 0);
        cur_rst = 1'b0;
        for (int k = 0; k < 20; k++) cycle(1'b1);
        chk("sat_tie4", sif.tie_cnt, 15);
        chk("sat_tie16", bif.tie_cnt, 20);

        // Random run with a mid-run reset
        for (int k = 0; k < 3000; k++) begin
            cur_rst  = (k == 1500);
            cur_code = int'($urandom_range(7, 0));
            cur_en   = ($urandom_range(9, 0) != 0);
            cur_clr  = ($urandom_range(15, 0) == 0);
            for (int i = 0; i < 6; i++)
                cur_s[i] = ($urandom_range(1, 0) != 0) ? int'($urandom_range(3, 0))
                                                       : int'($urandom_range(63, 0));
            cycle(1'b1);
            if (k == 1500) begin
                chk("midrst_ptr", bif.ptr, 0);
                chk("midrst_tie", bif.tie_cnt, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
